// File: rtl/seg_pkg.sv
// Shared constants for the 6-digit multiplexed 7-segment display driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Decimal point lit (active-low) after the HH and MM groups.
  localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 6'b111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Scans six BCD clock digits onto a common-anode display, one digit per CLK_DIV cycles.
// Optional macro SEGMUX_LZB_EN blanks a leading zero in the hours-tens digit.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  input  logic [3:0] hr_ones,
  input  logic [3:0] hr_tens,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
  localparam logic [2:0]    D_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] pcnt;
  logic [2:0]    d;
  logic [3:0]    shadow [NUM_DIGITS];
  logic          tick;
  logic [3:0]    digit_val;
  logic [6:0]    dec_seg;
  logic [6:0]    next_seg;

  assign tick = (pcnt == PCNT_MAX);

  // Digit 0 bypasses the shadow so it shows the value captured on this same tick.
  always_comb begin
    digit_val = shadow[d];
    if (d == 3'd0) digit_val = sec_ones;
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_val),
    .seg (dec_seg)
  );

  always_comb begin
    next_seg = dec_seg;
`ifdef SEGMUX_LZB_EN
    if (d == D_LAST && shadow[NUM_DIGITS-1] == 4'd0) next_seg = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      d    <= '0;
      an   <= AN_OFF;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        an  <= ~(6'b000001 << d);
        seg <= next_seg;
        dp  <= ~DP_MASK[d];
        d   <= (d == D_LAST) ? 3'd0 : d + 3'd1;
        if (d == 3'd0) begin
          shadow[0] <= sec_ones;
          shadow[1] <= sec_tens;
          shadow[2] <= min_ones;
          shadow[3] <= min_tens;
          shadow[4] <= hr_ones;
          shadow[5] <= hr_tens;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux with CLK_DIV=4: scan order, hold between ticks,
// invalid BCD, frame snapshot, mid-scan reset and hours-tens blanking.
module tb_seg_display_mux;

  localparam int CLK_DIV = 4;
  localparam logic [13:0] DARK = {6'h3F, 7'h7F, 1'b1};

  logic       clk;
  logic       rst;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [13:0] out_w;

  int checks = 0;
  int errors = 0;
  logic [13:0] last_out;
  logic [13:0] exp_q[$];

  typedef struct {
    logic [23:0] digits;  // {hr_tens,hr_ones,min_tens,min_ones,sec_tens,sec_ones}
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t scan_tbl[6];

  seg_display_mux #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .min_tens (min_tens),
    .hr_ones  (hr_ones),
    .hr_tens  (hr_tens),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  assign out_w = {an, seg, dp};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_digits(input logic [23:0] v);
    {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = v;
  endtask

  task automatic push_exp(input logic [5:0] a, input logic [6:0] s, input logic p);
    exp_q.push_back({a, s, p});
  endtask

  // Scoreboard
  task automatic compare(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               name, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
    end
  endtask

  // Outputs must hold for CLK_DIV-1 cycles, then change to the next queued value.
  task automatic tick_check(input string name);
    logic [13:0] exp;
    for (int i = 0; i < CLK_DIV - 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare({name, "_hold"}, out_w, last_out);
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at tick, got an=%h seg=%h dp=%b",
               name, an, seg, dp);
    end else begin
      exp = exp_q.pop_front();
      compare(name, out_w, exp);
      last_out = exp;
    end
  endtask

  initial begin
    scan_tbl[0] = '{24'h123456, 6'h3E, 7'h02, 1'b1};
    scan_tbl[1] = '{24'h123456, 6'h3D, 7'h12, 1'b1};
    scan_tbl[2] = '{24'h123456, 6'h3B, 7'h19, 1'b0};
    scan_tbl[3] = '{24'h123456, 6'h37, 7'h30, 1'b1};
    scan_tbl[4] = '{24'h123456, 6'h2F, 7'h24, 1'b0};
    scan_tbl[5] = '{24'h123456, 6'h1F, 7'h79, 1'b1};

    rst = 1'b1;
    set_digits(24'h123456);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      compare("reset_dark", out_w, DARK);
    end
    rst = 1'b0;
    last_out = DARK;

    // Scan order, two full frames from the table
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6; i++) begin
        set_digits(scan_tbl[i].digits);
        push_exp(scan_tbl[i].an, scan_tbl[i].seg, scan_tbl[i].dp);
        tick_check("scan");
      end
    end

    // Invalid BCD in min_tens
    set_digits(24'h12C456);
    push_exp(6'h3E, 7'h02, 1'b1);
    push_exp(6'h3D, 7'h12, 1'b1);
    push_exp(6'h3B, 7'h19, 1'b0);
    push_exp(6'h37, 7'h3F, 1'b1);
    push_exp(6'h2F, 7'h24, 1'b0);
    push_exp(6'h1F, 7'h79, 1'b1);
    for (int i = 0; i < 6; i++) tick_check("bad_bcd");

    // Snapshot coherence: change inputs two ticks into a frame
    set_digits(24'h123456);
    push_exp(6'h3E, 7'h02, 1'b1);
    push_exp(6'h3D, 7'h12, 1'b1);
    tick_check("snap_a");
    tick_check("snap_a");
    set_digits(24'h123500);
    push_exp(6'h3B, 7'h19, 1'b0);
    push_exp(6'h37, 7'h30, 1'b1);
    push_exp(6'h2F, 7'h24, 1'b0);
    push_exp(6'h1F, 7'h79, 1'b1);
    for (int i = 0; i < 4; i++) tick_check("snap_old");
    push_exp(6'h3E, 7'h40, 1'b1);
    push_exp(6'h3D, 7'h40, 1'b1);
    push_exp(6'h3B, 7'h12, 1'b0);
    push_exp(6'h37, 7'h30, 1'b1);
    push_exp(6'h2F, 7'h24, 1'b0);
    push_exp(6'h1F, 7'h79, 1'b1);
    for (int i = 0; i < 6; i++) tick_check("snap_new");

    // Hours-tens zero: blanked only in the LZB build
    set_digits(24'h090000);
    push_exp(6'h3E, 7'h40, 1'b1);
    push_exp(6'h3D, 7'h40, 1'b1);
    push_exp(6'h3B, 7'h40, 1'b0);
    push_exp(6'h37, 7'h40, 1'b1);
    push_exp(6'h2F, 7'h10, 1'b0);
`ifdef SEGMUX_LZB_EN
    push_exp(6'h1F, 7'h7F, 1'b1);
`else
    push_exp(6'h1F, 7'h40, 1'b1);
`endif
    for (int i = 0; i < 6; i++) tick_check("lzb");

    // Mid-scan reset while the digit index is 3
    set_digits(24'h123456);
    push_exp(6'h3E, 7'h02, 1'b1);
    push_exp(6'h3D, 7'h12, 1'b1);
    push_exp(6'h3B, 7'h19, 1'b0);
    for (int i = 0; i < 3; i++) tick_check("pre_rst");
    @(posedge clk);
    @(negedge clk);
    compare("pre_rst_hold", out_w, last_out);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compare("rst_dark", out_w, DARK);
    @(posedge clk);
    @(negedge clk);
    compare("rst_dark", out_w, DARK);
    rst = 1'b0;
    last_out = DARK;
    for (int i = 0; i < 6; i++) begin
      push_exp(scan_tbl[i].an, scan_tbl[i].seg, scan_tbl[i].dp);
      tick_check("post_rst");
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
